opl_timer_bank: RTL and testbench

- Parametrised successor to the fixed two-timer block of the OPL3 core.
- Provides NUM_TIMERS up-counting interval timers with per-timer prescale, preset reload, masking, a sticky overflow status and an active-low IRQ.
- Sits beside host_if in the OPL3 top level.
  - Fed by a base tick from a clk_div instance.
  - Fed by decoded register-write strobes from host_if.
  - Drives status bits and irq_n back to the host.

---
 rtl/opl3_pkg.sv | 35 +++
 rtl/opl_timer_channel.sv | 110 +++++++++++
 rtl/opl_timer_bank.sv | 155 +++++++++++++++
 tb/tb_opl_timer_bank.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/opl3_pkg.sv
// ---------------------------------------------------------------------------
// opl3_pkg
//   Shared constants and types for the OPL3 core timer bank.
//   - NUM_TIMERS_DEFAULT / TIMER_CNT_W : default timer count and counter width.
//   - TIMER_MAX / TIMER_DATA_MAX_W     : upper bounds used to size the packed
//                                        control/preset write structs so they
//                                        fit any legal parameterisation.
//   - opl_timer_ctrl_t                 : decoded control write payload.
//   - opl_timer_preset_wr_t            : decoded preset write.
//   - timer_sel_w()                    : index width for a timer select (min 1).
// ---------------------------------------------------------------------------
package opl3_pkg;

   localparam int NUM_TIMERS_DEFAULT = 2;
   localparam int TIMER_CNT_W        = 8;
   localparam int TIMER_MAX          = 8;
   localparam int TIMER_DATA_MAX_W   = 32;

   typedef struct packed {
      logic                   irq_rst;
      logic [TIMER_MAX-1:0]   mask;
      logic [TIMER_MAX-1:0]   start;
   } opl_timer_ctrl_t;

   typedef struct packed {
      logic                        en;
      logic [2:0]                  sel;
      logic [TIMER_DATA_MAX_W-1:0] data;
   } opl_timer_preset_wr_t;

   function automatic int timer_sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/opl_timer_channel.sv
// ---------------------------------------------------------------------------
// opl_timer_channel
//   One interval timer: optional prescaler, up-counter with preset reload,
//   and a sticky overflow flag.
//   Ports:
//     clk, arst_n   : clock, asynchronous active-low reset
//     tick_en       : base tick pulse
//     run           : timer running (registered start bit)
//     load          : start edge; load counter from preset, zero prescaler
//     force_ovf     : debug; overflow now if running
//     mask          : masked overflows do not set the flag
//     flag_clr_lo   : clear flag, loses against a same-cycle overflow
//     flag_clr_hi   : clear flag, wins against a same-cycle overflow
//     preset_we     : preset write strobe for this channel
//     preset_data   : preset value
//     flag          : sticky overflow flag
//     count         : current counter value
// ---------------------------------------------------------------------------
module opl_timer_channel #(
   parameter int CNT_W      = 8,
   parameter int PRESCALE_W = 0
)(
   input  logic             clk,
   input  logic             arst_n,
   input  logic             tick_en,
   input  logic             run,
   input  logic             load,
   input  logic             force_ovf,
   input  logic             mask,
   input  logic             flag_clr_lo,
   input  logic             flag_clr_hi,
   input  logic             preset_we,
   input  logic [CNT_W-1:0] preset_data,
   output logic             flag,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] preset_q, preset_d;
   logic             flag_q, flag_d;
   logic             timer_tick;
   logic             ovf;

   generate
      if (PRESCALE_W == 0) begin : g_no_psc
         assign timer_tick = run & tick_en;
      end else begin : g_psc
         logic [PRESCALE_W-1:0] psc_q, psc_d;

         // Free-running wrap: all-ones + 1 returns to zero on the tick.
         always_comb begin
            psc_d = psc_q;
            if (load)
               psc_d = '0;
            else if (run && tick_en)
               psc_d = psc_q + PRESCALE_W'(1);
         end

         always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) psc_q <= '0;
            else         psc_q <= psc_d;
         end

         assign timer_tick = run & tick_en & (&psc_q);
      end
   endgenerate

   // A forced overflow behaves like a tick at terminal count.
   assign ovf = run & (force_ovf | (timer_tick & (&cnt_q)));

   always_comb begin
      cnt_d    = cnt_q;
      preset_d = preset_q;
      flag_d   = flag_q;

      if (preset_we)
         preset_d = preset_data;

      // The stored (pre-write) preset is what reloads; a same-cycle write
      // only takes effect from the next reload onwards.
      if (load || ovf)
         cnt_d = preset_q;
      else if (timer_tick)
         cnt_d = cnt_q + CNT_W'(1);

      // Priority: irq reset < overflow < mask-set clear.
      if (flag_clr_lo)
         flag_d = 1'b0;
      if (ovf && !mask)
         flag_d = 1'b1;
      if (flag_clr_hi)
         flag_d = 1'b0;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         cnt_q    <= '0;
         preset_q <= '0;
         flag_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         preset_q <= preset_d;
         flag_q   <= flag_d;
      end
   end

   assign flag  = flag_q;
   assign count = cnt_q;

endmodule

// File: rtl/opl_timer_bank.sv
// ---------------------------------------------------------------------------
// opl_timer_bank
//   NUM_TIMERS up-counting interval timers with per-timer prescale
//   (timer i advances every 2^(i*PRESCALE_STEP_LOG2) base ticks), preset
//   reload, masking, sticky overflow flags and an active-low IRQ.
//   Optional macro: OPL_TIMER_READBACK_EN enables a registered counter
//   readback port; otherwise count_rd_data is tied to zero.
//   Ports:
//     clk, arst_n               : clock, asynchronous active-low reset
//     tick_en                   : base tick pulse
//     preset_wr_en/_sel/_data   : preset write
//     ctrl_wr_en                : control write strobe qualifying
//       ctrl_irq_rst, ctrl_mask, ctrl_start
//     force_timer_overflow      : debug overflow on all running timers
//     status                    : {OR of flags, flags}
//     irq_n                     : registered active-low interrupt
//     count_rd_sel/count_rd_data: counter readback (optional)
// ---------------------------------------------------------------------------
module opl_timer_bank
   import opl3_pkg::*;
#(
   parameter int NUM_TIMERS         = NUM_TIMERS_DEFAULT,
   parameter int CNT_W              = TIMER_CNT_W,
   parameter int PRESCALE_STEP_LOG2 = 2
)(
   input  logic                                clk,
   input  logic                                arst_n,
   input  logic                                tick_en,
   input  logic                                preset_wr_en,
   input  logic [timer_sel_w(NUM_TIMERS)-1:0]  preset_wr_sel,
   input  logic [CNT_W-1:0]                    preset_wr_data,
   input  logic                                ctrl_wr_en,
   input  logic                                ctrl_irq_rst,
   input  logic [NUM_TIMERS-1:0]               ctrl_mask,
   input  logic [NUM_TIMERS-1:0]               ctrl_start,
   input  logic                                force_timer_overflow,
   output logic [NUM_TIMERS:0]                 status,
   output logic                                irq_n,
   input  logic [timer_sel_w(NUM_TIMERS)-1:0]  count_rd_sel,
   output logic [CNT_W-1:0]                    count_rd_data
);

   opl_timer_ctrl_t      ctrl_w;
   opl_timer_preset_wr_t pw_w;

   logic [NUM_TIMERS-1:0] start_q, start_d;
   logic [NUM_TIMERS-1:0] mask_q, mask_d;
   logic                  irq_n_q, irq_n_d;
   logic [NUM_TIMERS-1:0] load_w;
   logic [NUM_TIMERS-1:0] flag_w;
   logic [NUM_TIMERS-1:0] mask_wr_clr_w;
   logic [NUM_TIMERS-1:0] preset_we_w;
   logic [NUM_TIMERS-1:0][CNT_W-1:0] count_w;
   logic                  ctrl_latch_w;
   logic                  flag_clr_all_w;
   logic                  preset_valid_w;
   logic                  unused_pkg_bits;

   always_comb begin
      ctrl_w         = '0;
      ctrl_w.irq_rst = ctrl_irq_rst;
      ctrl_w.mask    = TIMER_MAX'(ctrl_mask);
      ctrl_w.start   = TIMER_MAX'(ctrl_start);

      pw_w      = '0;
      pw_w.en   = preset_wr_en;
      pw_w.sel  = 3'(preset_wr_sel);
      pw_w.data = TIMER_DATA_MAX_W'(preset_wr_data);
   end

   // Struct bits beyond the configured size are intentionally ignored.
   assign unused_pkg_bits = ^{ctrl_w, pw_w};

   // An irq-reset write ignores mask/start entirely.
   assign ctrl_latch_w   = ctrl_wr_en & ~ctrl_w.irq_rst;
   assign flag_clr_all_w = ctrl_wr_en &  ctrl_w.irq_rst;
   assign preset_valid_w = pw_w.en & (int'(pw_w.sel) < NUM_TIMERS);

   always_comb begin
      start_d = start_q;
      mask_d  = mask_q;
      if (ctrl_latch_w) begin
         start_d = ctrl_w.start[NUM_TIMERS-1:0];
         mask_d  = ctrl_w.mask[NUM_TIMERS-1:0];
      end
      irq_n_d = ~(|flag_w);
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         start_q <= '0;
         mask_q  <= '0;
         irq_n_q <= 1'b1;
      end else begin
         start_q <= start_d;
         mask_q  <= mask_d;
         irq_n_q <= irq_n_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_TIMERS; gi++) begin : g_timer
         assign load_w[gi]        = start_d[gi] & ~start_q[gi];
         assign mask_wr_clr_w[gi] = ctrl_latch_w & ctrl_w.mask[gi];
         assign preset_we_w[gi]   = preset_valid_w & (pw_w.sel == 3'(gi));

         opl_timer_channel #(
            .CNT_W      (CNT_W),
            .PRESCALE_W (gi * PRESCALE_STEP_LOG2)
         ) u_chan (
            .clk         (clk),
            .arst_n      (arst_n),
            .tick_en     (tick_en),
            .run         (start_q[gi]),
            .load        (load_w[gi]),
            .force_ovf   (force_timer_overflow),
            .mask        (mask_q[gi]),
            .flag_clr_lo (flag_clr_all_w),
            .flag_clr_hi (mask_wr_clr_w[gi]),
            .preset_we   (preset_we_w[gi]),
            .preset_data (pw_w.data[CNT_W-1:0]),
            .flag        (flag_w[gi]),
            .count       (count_w[gi])
         );
      end
   endgenerate

   // Flags are flops; status follows them on the same edge.
   assign status = {|flag_w, flag_w};
   assign irq_n  = irq_n_q;

`ifdef OPL_TIMER_READBACK_EN
   logic [CNT_W-1:0] rd_q, rd_d;

   always_comb begin
      rd_d = '0;
      if (int'(count_rd_sel) < NUM_TIMERS)
         rd_d = count_w[count_rd_sel];
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) rd_q <= '0;
      else         rd_q <= rd_d;
   end

   assign count_rd_data = rd_q;
`else
   logic unused_readback;

   assign unused_readback = ^{count_rd_sel, count_w};
   assign count_rd_data   = '0;
`endif

endmodule

// File: tb/tb_opl_timer_bank.sv
// Directed bench for opl_timer_bank at default parameters
// (2 timers, 8-bit counters, timer1 prescale 4).
module tb_opl_timer_bank;

   logic       clk = 1'b0;
   logic       arst_n = 1'b1;
   logic       tick_en = 1'b0;
   logic       preset_wr_en = 1'b0;
   logic [0:0] preset_wr_sel = '0;
   logic [7:0] preset_wr_data = '0;
   logic       ctrl_wr_en = 1'b0;
   logic       ctrl_irq_rst = 1'b0;
   logic [1:0] ctrl_mask = '0;
   logic [1:0] ctrl_start = '0;
   logic       force_timer_overflow = 1'b0;
   logic [2:0] status;
   logic       irq_n;
   logic [0:0] count_rd_sel = '0;
   logic [7:0] count_rd_data;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   opl_timer_bank dut (
      .clk                  (clk),
      .arst_n               (arst_n),
      .tick_en              (tick_en),
      .preset_wr_en         (preset_wr_en),
      .preset_wr_sel        (preset_wr_sel),
      .preset_wr_data       (preset_wr_data),
      .ctrl_wr_en           (ctrl_wr_en),
      .ctrl_irq_rst         (ctrl_irq_rst),
      .ctrl_mask            (ctrl_mask),
      .ctrl_start           (ctrl_start),
      .force_timer_overflow (force_timer_overflow),
      .status               (status),
      .irq_n                (irq_n),
      .count_rd_sel         (count_rd_sel),
      .count_rd_data        (count_rd_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One clock; strobes drop back to idle 1 time unit after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
      tick_en              = 1'b0;
      preset_wr_en         = 1'b0;
      ctrl_wr_en           = 1'b0;
      ctrl_irq_rst         = 1'b0;
      force_timer_overflow = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         tick_en = 1'b1;
         cyc();
      end
   endtask

   task automatic preset(input logic sel, input logic [7:0] data);
      preset_wr_en   = 1'b1;
      preset_wr_sel  = sel;
      preset_wr_data = data;
      cyc();
   endtask

   task automatic ctrl(input logic irq, input logic [1:0] m, input logic [1:0] s);
      ctrl_wr_en   = 1'b1;
      ctrl_irq_rst = irq;
      ctrl_mask    = m;
      ctrl_start   = s;
      cyc();
   endtask

   initial begin
      // Reset
      #2 arst_n = 1'b0;
      #1;
      chk("rst_status", 32'(status), 32'h0);
      chk("rst_irq_n", 32'(irq_n), 32'h1);
      chk("rst_rd", 32'(count_rd_data), 32'h0);
      @(negedge clk) arst_n = 1'b1;
      cyc();

      // Timer0 from 0xFE: overflow on the 2nd tick
      preset(1'b0, 8'hFE);
      ctrl(1'b0, 2'b00, 2'b01);
      chk("t1_start", 32'(status), 32'h0);
      ticks(1);
      chk("t1_tick1", 32'(status), 32'h0);
      ticks(1);
      chk("t1_ovf_stat", 32'(status), 32'h5);
      chk("t1_ovf_irq", 32'(irq_n), 32'h1);
      cyc();
      chk("t1_irq_low", 32'(irq_n), 32'h0);
      ticks(1);
      chk("t1_tick3", 32'(status), 32'h5);
      ctrl(1'b1, 2'b11, 2'b11);
      chk("t1_clr_stat", 32'(status), 32'h0);
      chk("t1_clr_irq", 32'(irq_n), 32'h0);
      cyc();
      chk("t1_irq_high", 32'(irq_n), 32'h1);
      ctrl(1'b0, 2'b00, 2'b00);

      // Timer1 prescale 4 from 0xFF; timer0 stopped at 0xFF must stay quiet
      preset(1'b1, 8'hFF);
      ctrl(1'b0, 2'b00, 2'b10);
      ticks(3);
      chk("t2_3ticks", 32'(status), 32'h0);
      ticks(1);
      chk("t2_4th", 32'(status), 32'h6);
      cyc();
      chk("t2_irq", 32'(irq_n), 32'h0);
      ctrl(1'b1, 2'b00, 2'b00);
      ctrl(1'b0, 2'b00, 2'b00);

      // Masked forced overflow, then unmasked
      ctrl(1'b0, 2'b01, 2'b01);
      force_timer_overflow = 1'b1;
      cyc();
      chk("t3_masked", 32'(status), 32'h0);
      cyc();
      chk("t3_mask_irq", 32'(irq_n), 32'h1);
      ctrl(1'b0, 2'b00, 2'b01);
      force_timer_overflow = 1'b1;
      cyc();
      chk("t3_unmasked", 32'(status), 32'h5);
      // overflow together with mask-set write: flag ends clear
      force_timer_overflow = 1'b1;
      ctrl(1'b0, 2'b01, 2'b01);
      chk("t3_ovf_mask", 32'(status), 32'h0);
      ctrl(1'b0, 2'b00, 2'b01);
      chk("t3_irq_back", 32'(irq_n), 32'h1);

      // Overflow coinciding with irq reset (counter at 0xFE)
      ticks(1);
      tick_en = 1'b1;
      ctrl(1'b1, 2'b00, 2'b01);
      chk("t4_ovf_rst", 32'(status), 32'h5);
      ctrl(1'b1, 2'b00, 2'b01);
      chk("t4_rst_stat", 32'(status), 32'h0);
      chk("t4_rst_irq", 32'(irq_n), 32'h0);
      cyc();
      chk("t4_irq_high", 32'(irq_n), 32'h1);

      // Preset write while running at 0x80
      preset(1'b0, 8'h80);
      ctrl(1'b0, 2'b00, 2'b00);
      ctrl(1'b0, 2'b00, 2'b01);
      preset(1'b0, 8'h10);
      ticks(127);
      chk("t5_to_ff", 32'(status), 32'h0);
      ticks(1);
      chk("t5_ovf", 32'(status), 32'h5);
      ctrl(1'b1, 2'b00, 2'b01);
      ticks(239);
      chk("t5_reload", 32'(status), 32'h0);
      ticks(1);
      chk("t5_ovf2", 32'(status), 32'h5);
      ctrl(1'b1, 2'b00, 2'b01);
      ticks(5);
      ctrl(1'b0, 2'b00, 2'b00);
      ctrl(1'b0, 2'b00, 2'b01);
      ticks(239);
      chk("t5_restart", 32'(status), 32'h0);
      ticks(1);
      chk("t5_ovf3", 32'(status), 32'h5);
      ctrl(1'b1, 2'b00, 2'b01);

      // Readback: timer0 from 0x00 after 5 ticks
      preset(1'b0, 8'h00);
      ctrl(1'b0, 2'b00, 2'b00);
      ctrl(1'b0, 2'b00, 2'b01);
      count_rd_sel = 1'b0;
      ticks(5);
      cyc();
`ifdef OPL_TIMER_READBACK_EN
      chk("t6_rd_t0", 32'(count_rd_data), 32'h05);
      count_rd_sel = 1'b1;
      cyc();
      chk("t6_rd_t1", 32'(count_rd_data), 32'hFF);
`else
      chk("t6_rd_tied", 32'(count_rd_data), 32'h0);
`endif

      // Asynchronous reset mid-count with a flag set
      force_timer_overflow = 1'b1;
      cyc();
      chk("t7_pre_stat", 32'(status), 32'h5);
      cyc();
      chk("t7_pre_irq", 32'(irq_n), 32'h0);
      #2 arst_n = 1'b0;
      #1;
      chk("t7_rst_stat", 32'(status), 32'h0);
      chk("t7_rst_irq", 32'(irq_n), 32'h1);
      chk("t7_rst_rd", 32'(count_rd_data), 32'h0);
      @(negedge clk) arst_n = 1'b1;
      cyc();
      tick_en = 1'b1;
      force_timer_overflow = 1'b1;
      cyc();
      chk("t7_stopped", 32'(status), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
